// File: rtl/pixel_block_reducer.sv
// Walks a SRC_W x SRC_H frame in FACTOR x FACTOR blocks through a synchronous-read memory
// and reduces each block to a single pixel (average, nearest, max or min).
module pixel_block_reducer #(
    parameter int SRC_W   = 320,
    parameter int SRC_H   = 240,
    parameter int FACTOR  = 2,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 17,
    parameter int OADDR_W = 15,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_pixel,
    output logic [OADDR_W-1:0] out_addr,
    output logic               busy,
    output logic               done
);

    localparam int SHIFT = 2 * $clog2(FACTOR);
    localparam int SUM_W = DATA_W + SHIFT;
    localparam int BW    = SRC_W / FACTOR;
    localparam int BH    = SRC_H / FACTOR;
    localparam int BXW   = (BW > 1) ? $clog2(BW) : 1;
    localparam int BYW   = (BH > 1) ? $clog2(BH) : 1;
    localparam int IW    = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam int CW    = $clog2(FACTOR * FACTOR) + 1;

    localparam logic [BXW-1:0]    BX_LAST   = BXW'(BW - 1);
    localparam logic [BYW-1:0]    BY_LAST   = BYW'(BH - 1);
    localparam logic [IW-1:0]     I_LAST    = IW'(FACTOR - 1);
    localparam logic [CW-1:0]     N_LAST    = CW'(FACTOR * FACTOR - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(FACTOR);
    localparam logic [ADDR_W-1:0] BROW_STEP = ADDR_W'(SRC_W * FACTOR);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, FIN} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [BXW-1:0]     bx;
    logic [BYW-1:0]     by;
    logic [IW-1:0]      i_cnt;
    logic [IW-1:0]      j_cnt;
    logic [ADDR_W-1:0]  row_base;
    logic [ADDR_W-1:0]  blk_base;
    logic [ADDR_W-1:0]  brow_base;
    logic [ADDR_W-1:0]  nxt_base;
    logic [RD_LAT-1:0]  vld_p;
    logic [CW-1:0]      ret_cnt;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   acc_nxt;
    logic               ret_vld;

    // First sample of a block seeds the accumulator regardless of mode.
    function automatic logic [SUM_W-1:0] acc_step(input logic [1:0] m, input logic first,
                                                  input logic [SUM_W-1:0] a,
                                                  input logic [DATA_W-1:0] d);
        logic [SUM_W-1:0] dx;
        dx = SUM_W'(d);
        if (first) begin
            return dx;
        end
        case (m)
            2'b00:   return a + dx;
            2'b01:   return a;
            2'b10:   return (dx > a) ? dx : a;
            default: return (dx < a) ? dx : a;
        endcase
    endfunction

    // Truncating average; the sum of FACTOR^2 pixels shifted back always fits DATA_W.
    function automatic logic [DATA_W-1:0] reduce_block(input logic [1:0] m,
                                                       input logic [SUM_W-1:0] a);
        logic [SUM_W-1:0] shifted;
        shifted = a >> SHIFT;
        if (m == 2'b00) begin
            return shifted[DATA_W-1:0];
        end
        return a[DATA_W-1:0];
    endfunction

    assign ret_vld  = vld_p[RD_LAT-1];
    assign acc_nxt  = acc_step(mode_q, (ret_cnt == '0), acc, rd_data);
    assign nxt_base = (bx == BX_LAST) ? (brow_base + BROW_STEP) : (blk_base + BLK_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 2'b00;
            bx        <= '0;
            by        <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            row_base  <= '0;
            blk_base  <= '0;
            brow_base <= '0;
            vld_p     <= '0;
            ret_cnt   <= '0;
            acc       <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Read-return tag pipeline: the tag leaving the last stage marks rd_data as valid.
            vld_p[0] <= rd_en;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            if (ret_vld) begin
                acc     <= acc_nxt;
                ret_cnt <= ret_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        bx        <= '0;
                        by        <= '0;
                        i_cnt     <= '0;
                        j_cnt     <= '0;
                        row_base  <= '0;
                        blk_base  <= '0;
                        brow_base <= '0;
                        ret_cnt   <= '0;
                        out_addr  <= '0;
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (i_cnt == I_LAST) begin
                        i_cnt <= '0;
                        if (j_cnt == I_LAST) begin
                            j_cnt <= '0;
                            rd_en <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            j_cnt    <= j_cnt + 1'b1;
                            row_base <= row_base + ROW_STEP;
                            rd_addr  <= row_base + ROW_STEP;
                        end
                    end else begin
                        i_cnt   <= i_cnt + 1'b1;
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (ret_vld && (ret_cnt == N_LAST)) begin
                        out_pixel <= reduce_block(mode_q, acc_nxt);
                        out_valid <= 1'b1;
                        ret_cnt   <= '0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if ((bx == BX_LAST) && (by == BY_LAST)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            out_addr <= out_addr + 1'b1;
                            if (bx == BX_LAST) begin
                                bx        <= '0;
                                by        <= by + 1'b1;
                                brow_base <= nxt_base;
                            end else begin
                                bx <= bx + 1'b1;
                            end
                            blk_base <= nxt_base;
                            row_base <= nxt_base;
                            rd_addr  <= nxt_base;
                            rd_en    <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_block_reducer.sv
// Scoreboard bench for pixel_block_reducer: an 8x4/FACTOR=2 instance with address-valued memory
// and an 8x8/FACTOR=4/RD_LAT=3 instance with all-255 memory.
module tb_pixel_block_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 8x4 frame, 2x2 blocks, one-cycle memory
    logic       start_a;
    logic [1:0] mode_a;
    logic       rd_en_a;
    logic [4:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic       ov_a;
    logic       ordy_a;
    logic [7:0] pix_a;
    logic [2:0] oadr_a;
    logic       busy_a;
    logic       done_a;

    pixel_block_reducer #(.SRC_W(8), .SRC_H(4), .FACTOR(2), .DATA_W(8),
                          .ADDR_W(5), .OADDR_W(3), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .out_valid(ov_a), .out_ready(ordy_a), .out_pixel(pix_a), .out_addr(oadr_a),
        .busy(busy_a), .done(done_a)
    );

    always @(posedge clk) rd_data_a <= rd_en_a ? {3'b000, rd_addr_a} : 8'hEE;

    // Instance B: 8x8 frame, 4x4 blocks, three-cycle memory, every pixel 255
    logic       start_b;
    logic [1:0] mode_b;
    logic       rd_en_b;
    logic [5:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic       ov_b;
    logic       ordy_b;
    logic [7:0] pix_b;
    logic [1:0] oadr_b;
    logic       busy_b;
    logic       done_b;
    logic [7:0] m1, m2, m3;

    assign ordy_b = 1'b1;

    pixel_block_reducer #(.SRC_W(8), .SRC_H(8), .FACTOR(4), .DATA_W(8),
                          .ADDR_W(6), .OADDR_W(2), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .out_valid(ov_b), .out_ready(ordy_b), .out_pixel(pix_b), .out_addr(oadr_b),
        .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) begin
        m1 <= rd_en_b ? 8'hFF : 8'h00;
        m2 <= m1;
        m3 <= m2;
    end
    assign rd_data_b = m3;

    int errors = 0;
    int checks = 0;
    int qp_a[$], qa_a[$], qp_b[$], qa_b[$];
    int dc_a = 0;
    int dc_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference for the 8x4 address-valued frame
    function automatic int model_a(input int m, input int bx, input int by);
        int s, mx, mn, v;
        s = 0; mx = 0; mn = 255;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 2; i++) begin
                v = (by * 2 + j) * 8 + bx * 2 + i;
                s += v;
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
        end
        case (m)
            0: return s / 4;
            1: return (by * 2) * 8 + bx * 2;
            2: return mx;
            default: return mn;
        endcase
    endfunction

    task automatic push_a(input int m, input int n);
        for (int k = 0; k < n; k++) begin
            qp_a.push_back(model_a(m, k % 4, k / 4));
            qa_a.push_back(k);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done_a) dc_a++;
            if (ov_a && ordy_a) begin
                if (qp_a.size() == 0) chk("a_unexpected_output", 1, 0);
                else begin
                    chk("a_pixel", pix_a, qp_a.pop_front());
                    chk("a_addr", oadr_a, qa_a.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done_b) dc_b++;
            if (ov_b && ordy_b) begin
                if (qp_b.size() == 0) chk("b_unexpected_output", 1, 0);
                else begin
                    chk("b_pixel", pix_b, qp_b.pop_front());
                    chk("b_addr", oadr_b, qa_b.pop_front());
                end
            end
        end
    end

    task automatic chk_idle_a(input string tag);
        chk({tag, "_rd_en"}, rd_en_a, 0);
        chk({tag, "_rd_addr"}, rd_addr_a, 0);
        chk({tag, "_out_valid"}, ov_a, 0);
        chk({tag, "_out_pixel"}, pix_a, 0);
        chk({tag, "_out_addr"}, oadr_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
    endtask

    task automatic start_pass_a(input logic [1:0] m);
        @(posedge clk); #1;
        mode_a  = m;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        bit seen;
        seen = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done_a) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({tag, "_timeout_done"}, 0, 1);
        else begin
            chk({tag, "_done_addr"}, oadr_a, 7);
            chk({tag, "_busy_at_done"}, busy_a, 0);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, dc_a, 1);
        chk({tag, "_queue_empty"}, qp_a.size(), 0);
        chk({tag, "_addr_hold"}, oadr_a, 7);
    endtask

    // Full pass on A; optionally toggles mode and re-pulses start after block 0
    task automatic run_full_a(input logic [1:0] m, input bit disturb, input string tag);
        int t0, lat;
        bit got;
        dc_a = 0;
        push_a(m, 8);
        start_pass_a(m);
        t0 = -1; got = 0; lat = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n == 0) chk({tag, "_busy_after_start"}, busy_a, 1);
            if (t0 < 0 && rd_en_a) t0 = cyc;
            if (ov_a && ordy_a) begin
                got = 1;
                lat = cyc - t0 + 1;
                break;
            end
        end
        if (!got) chk({tag, "_timeout_first"}, 0, 1);
        else chk({tag, "_latency"}, lat, 6);
        if (disturb) begin
            @(posedge clk); #1;
            mode_a  = ~m;
            start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        wait_done_a(tag);
    endtask

    initial begin
        bit got;
        int t0, lat;
        rst = 1'b1;
        start_a = 1'b0; mode_a = 2'b00; ordy_a = 1'b1;
        start_b = 1'b0; mode_b = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_a("reset");
        chk("reset_b_busy", busy_b, 0);
        chk("reset_b_valid", ov_b, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_full_a(2'b00, 1'b0, "avg");
        run_full_a(2'b10, 1'b1, "max_disturbed");
        run_full_a(2'b11, 1'b0, "min");
        run_full_a(2'b01, 1'b0, "nearest");

        // Backpressure on block 2
        dc_a = 0;
        push_a(0, 8);
        start_pass_a(2'b00);
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ov_a && oadr_a == 3'd1) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("bp_timeout_blk1", 0, 1);
        @(posedge clk); #1;
        ordy_a = 1'b0;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ov_a) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("bp_timeout_blk2", 0, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_valid_held", ov_a, 1);
            chk("bp_pixel_stable", pix_a, 8);
            chk("bp_addr_stable", oadr_a, 2);
            chk("bp_no_read", rd_en_a, 0);
        end
        @(posedge clk); #1;
        ordy_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_rd_en", rd_en_a, 1);
        chk("bp_next_rd_addr", rd_addr_a, 6);
        wait_done_a("bp");

        // Reset during block 3 fetch
        push_a(0, 3);
        start_pass_a(2'b00);
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rd_en_a && rd_addr_a == 5'd7) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("rst_timeout_blk3", 0, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle_a("midrst");
        chk("midrst_queue_empty", qp_a.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_full_a(2'b00, 1'b0, "after_rst");

        // Saturation and three-cycle latency on B
        dc_b = 0;
        for (int k = 0; k < 4; k++) begin
            qp_b.push_back(255);
            qa_b.push_back(k);
        end
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        t0 = -1; got = 0; lat = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (t0 < 0 && rd_en_b) t0 = cyc;
            if (ov_b && ordy_b) begin
                got = 1;
                lat = cyc - t0 + 1;
                break;
            end
        end
        if (!got) chk("b_timeout_first", 0, 1);
        else chk("b_latency", lat, 20);
        got = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done_b) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("b_timeout_done", 0, 1);
        else chk("b_busy_at_done", busy_b, 0);
        repeat (3) @(negedge clk);
        chk("b_done_count", dc_b, 1);
        chk("b_queue_empty", qp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_block_reducer.md
Name: pixel_block_reducer

Overview:
- Parametrised successor to the team's fixed 2x2 pixel mapper. Walks a SRC_W x SRC_H 8-bit frame stored in a synchronous-read RAM/ROM and fetches each FACTOR x FACTOR block.
- Reduces each block to one pixel using a selectable mode: average, nearest, max or min.
- Emits each pixel with its output-frame address over a valid/ready handshake.
- Sits between the frame memory and the downscaled-frame writer or VGA buffer.

Parameters:
- SRC_W, 320, source frame width in pixels; must be a multiple of FACTOR.
- SRC_H, 240, source frame height in pixels; must be a multiple of FACTOR.
- FACTOR, 2, block edge; power of two in {1,2,4,8}.
- DATA_W, 8, pixel width.
- ADDR_W, 17, source address width; must satisfy 2^ADDR_W >= SRC_W*SRC_H.
- OADDR_W, 15, output address width; must satisfy 2^OADDR_W >= (SRC_W/FACTOR)*(SRC_H/FACTOR).
- RD_LAT, 1, memory read latency in cycles (1..3).

Ports:
- clk, in, 1: system clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: start one full-frame pass; sampled only in IDLE.
- mode, in, 2: 00 average, 01 nearest (top-left pixel), 10 max, 11 min; latched when start is accepted.
- rd_en, out, 1: memory read strobe.
- rd_addr, out, ADDR_W: memory read address.
- rd_data, in, DATA_W: read data, valid RD_LAT cycles after rd_en.
- out_valid, out, 1: out_pixel/out_addr valid.
- out_ready, in, 1: consumer accepts when out_valid && out_ready.
- out_pixel, out, DATA_W: reduced pixel.
- out_addr, out, OADDR_W: output-frame index, by*(SRC_W/FACTOR)+bx.
- busy, out, 1: high from start acceptance until done.
- done, out, 1: one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: state=IDLE. rd_en, rd_addr, out_valid, out_pixel, out_addr, busy and done all 0. Block counters, accumulator and latency pipeline cleared.
- States: IDLE, FETCH, DRAIN, EMIT, FIN.
- IDLE: start=1 → latch mode, bx=by=0, busy=1, go FETCH. start while busy is ignored.
- FETCH: issues FACTOR*FACTOR reads on consecutive cycles, rd_en=1 each cycle.
  - Read order is row-major within the block: i (column) inner, j (row) outer.
  - rd_addr = (by*FACTOR + j)*SRC_W + bx*FACTOR + i, computed incrementally with adders only (row base += SRC_W; no runtime multipliers).
  - After the last read, go DRAIN.
- DRAIN: wait until all RD_LAT-delayed returns have been accumulated, then go EMIT. rd_en=0.
- Return tracking: a RD_LAT-deep shift register of rd_en tags marks returning data.
  - First returned sample initialises the accumulator (sum, or min/max, or nearest).
  - Later samples: sum += d; max = d>max ? d : max; min = d<min ? d : min; nearest is unchanged.
- Arithmetic:
  - Sum width is DATA_W + 2*log2(FACTOR).
  - Average = sum >> 2*log2(FACTOR), truncating with no rounding; cannot overflow DATA_W.
  - FACTOR=1: every mode returns the sample unchanged.
- EMIT: out_valid=1 with out_pixel and out_addr held stable until out_ready=1.
  - No reads are issued while stalled.
  - On acceptance: if this was the last block, go FIN; otherwise advance bx and go FETCH. bx wraps at SRC_W/FACTOR-1 to 0 and by increments.
- Per-block latency with out_ready held at 1: FACTOR*FACTOR + RD_LAT + 1 cycles, from the first rd_en to the out_valid acceptance cycle.
- FIN: done=1 for one cycle, busy=0, return IDLE. out_addr holds the last value.
- out_addr increments by exactly 1 per accepted pixel, 0 .. (SRC_W/FACTOR)*(SRC_H/FACTOR)-1; no gaps or repeats.
- rst in any state (mid-FETCH, DRAIN, EMIT) → immediate IDLE with reset values; in-flight read data is discarded.
- mode changes during a pass have no effect.

Test Plan:
- Config SRC_W=8, SRC_H=4, FACTOR=2, RD_LAT=1; memory data = address. Mode 00, out_ready=1 → 8 outputs.
  - Block 0 reads addrs 0,1,8,9 → out_pixel=4, out_addr=0.
  - Block 1 reads 2,3,10,11 → 6.
  - Block 4 reads 16,17,24,25 → 20.
  - done pulses once after out_addr=7; busy falls the same cycle.
- Same memory, modes 10/11/01, block 0 → max 9, min 0, nearest 0. Block 5 (addrs 18,19,26,27) → max 27, min 18, nearest 18.
- Backpressure: hold out_ready=0 for 5 cycles at block 2.
  - out_valid stays 1 and out_pixel=8 is stable.
  - rd_en stays 0 throughout.
  - Block 3 fetch starts the cycle after acceptance.
- Saturation: all memory=255, FACTOR=4, SRC_W=SRC_H=8, mode 00 → 4 outputs, each 255, no wrap. RD_LAT=3 gives the same result with a latency of 16+3+1 cycles.
- Reset mid-FETCH of block 3 → next cycle all outputs 0, state IDLE. A new start restarts at out_addr=0 with correct values.
- start pulsed while busy, and mode toggled mid-pass → ignored: exactly one done, and results match the originally latched mode.
